// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream from the host link, assembles little-endian
// 32-bit instruction words and writes them to consecutive instruction-memory
// locations starting at word 0. The stream is a 16-bit little-endian word count N
// followed by 4*N data bytes. The core is held in reset while a session is running.
module imem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_r;
    logic [7:0]        len_lo_r;    // low byte of N, held until the high byte arrives
    logic [15:0]       len_r;       // word count N for the running session
    logic [1:0]        byte_idx_r;  // position of the next byte inside the current word
    logic [23:0]       asm_r;       // first three bytes of the word being assembled
    logic [ADDR_W:0]   addr_r;      // one extra bit so the count after the last word never wraps

    logic              xfer_s;
    logic [15:0]       len_full_s;
    logic [15:0]       next_count_s;

    // Handshake, header value and number of words written after the current write
    always_comb begin
        xfer_s       = byte_valid && byte_ready;
        len_full_s   = {byte_data, len_lo_r};
        next_count_s = 16'(addr_r) + 16'd1;
    end

    // Loader state machine; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            byte_idx_r <= 2'd0;
            asm_r      <= 24'd0;
            addr_r     <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    // start is only honoured when no session is running
                    if (start) begin
                        state_r    <= S_LEN_LO;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        addr_r     <= '0;
                        byte_idx_r <= 2'd0;
                        byte_ready <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer_s) begin
                        len_lo_r <= byte_data;
                        state_r  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer_s) begin
                        len_r <= len_full_s;
                        // Reject an empty program or one larger than the memory
                        if ((len_full_s == 16'd0) || (len_full_s > DEPTH_W)) begin
                            state_r    <= S_ERROR;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            state_r    <= S_DATA;
                            byte_idx_r <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        case (byte_idx_r)
                            2'd0: begin
                                asm_r[7:0] <= byte_data;
                                byte_idx_r <= 2'd1;
                            end
                            2'd1: begin
                                asm_r[15:8] <= byte_data;
                                byte_idx_r  <= 2'd2;
                            end
                            2'd2: begin
                                asm_r[23:16] <= byte_data;
                                byte_idx_r   <= 2'd3;
                            end
                            2'd3: begin
                                // Fourth byte completes the word; write it next cycle
                                mem_wdata  <= {byte_data, asm_r};
                                mem_waddr  <= addr_r[ADDR_W-1:0];
                                mem_we     <= 1'b1;
                                byte_ready <= 1'b0;
                                byte_idx_r <= 2'd0;
                                state_r    <= S_WRITE;
                            end
                            default: begin
                                byte_idx_r <= 2'd0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    mem_we <= 1'b0;
                    addr_r <= addr_r + {{ADDR_W{1'b0}}, 1'b1};
                    if (next_count_s == len_r) begin
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r    <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

    // The core is held in reset exactly while a session is in progress
    assign cpu_hold = busy;

endmodule
